l2_tile_rsp_model: RTL and testbench

// - Parametrised L2 responder for the multi-stream buffer read controller; replaces the one-deep register loopback.
// - Sits on the tile req/rsp pair of the read controller: o_tile_req_* -> i_req_*, o_rsp_* -> i_tile_rsp_*.
// - Per tile: in-order queue of up to DEPTH outstanding cacheline requests.
// - Each accepted request is returned LATENCY cycles after acceptance, or later under backpressure.

---
 rtl/msb_pkg.sv | 14 +
 rtl/l2_tile_rsp_chan.sv | 104 ++++++++++
 rtl/l2_tile_rsp_model.sv | 42 ++++
 tb/tb_l2_tile_rsp_model.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/msb_pkg.sv
// Shared sizing constants and the queue entry type for the L2 tile responder model.
package msb_pkg;

  localparam int clid_width = 4;
  localparam int TILES      = 4;
  localparam int DEPTH      = 8;
  localparam int LATENCY    = 4;

  typedef struct packed {
    logic [clid_width-1:0] clid;
    logic [7:0]            cnt;
  } l2_ent_t;

endpackage

// File: rtl/l2_tile_rsp_chan.sv
// One tile of the L2 responder: in-order queue with per-entry countdowns and a registered response port.
// Build option L2_STALL_INJ_EN adds a per-tile Galois LFSR that withholds new responses about 25% of the time.
module l2_tile_rsp_chan #(
  parameter int DEPTH    = msb_pkg::DEPTH,
  parameter int LATENCY  = msb_pkg::LATENCY,
`ifdef L2_STALL_INJ_EN
  parameter int TILE_IDX = 0,
`endif
  parameter int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_reqV,
  output logic                           o_reqRdy,
  input  logic [msb_pkg::clid_width-1:0] i_reqClid,
  output logic                           o_rspV,
  input  logic                           i_rspRdy,
  output logic [msb_pkg::clid_width-1:0] o_rspClid,
  output logic [OCC_W-1:0]               o_occ
);
  import msb_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  l2_ent_t               r_mem [DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic                  r_reqRdy;
  logic                  r_rspV;
  logic [clid_width-1:0] r_rspClid;

  logic [PW-1:0]         w_occ;
  logic [PW-1:0]         w_occNext;
  logic [AW-1:0]         w_nxtHead;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_headRdy;
  logic                  w_stall;
  logic                  w_rspVNext;

  assign w_push     = i_reqV & r_reqRdy;
  assign w_pop      = r_rspV & i_rspRdy;
  assign w_occ      = r_wrPtr - r_rdPtr;
  assign w_occNext  = w_occ + PW'(w_push) - PW'(w_pop);
  assign w_nxtHead  = r_rdPtr[AW-1:0] + AW'(w_pop);
  // Uses the pre-edge countdown, so o_rspV rises the cycle after the head reaches zero.
  assign w_headRdy  = ((w_occ - PW'(w_pop)) != '0) && (r_mem[w_nxtHead].cnt == 8'd0);
  assign w_rspVNext = (r_rspV && !w_pop) || (w_headRdy && !w_stall);

`ifdef L2_STALL_INJ_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1 ^ 16'(TILE_IDX);
    end else begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b11);
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_push && (r_wrPtr[AW-1:0] == AW'(k))) begin
          r_mem[k] <= '{clid: i_reqClid, cnt: 8'(LATENCY - 1)};
        end else if (r_mem[k].cnt != 8'd0) begin
          r_mem[k].cnt <= r_mem[k].cnt - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_reqRdy  <= 1'b1;
      r_rspV    <= 1'b0;
      r_rspClid <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      r_reqRdy <= (w_occNext != PW'(DEPTH));
      r_rspV   <= w_rspVNext;
      if (w_rspVNext) r_rspClid <= r_mem[w_nxtHead].clid;
    end
  end

  assign o_reqRdy  = r_reqRdy;
  assign o_rspV    = r_rspV;
  assign o_rspClid = r_rspClid;
  assign o_occ     = OCC_W'(w_occ);

endmodule

// File: rtl/l2_tile_rsp_model.sv
// Parametrised L2 responder: TILES independent in-order channels behind the read controller's tile req/rsp ports.
// Build option L2_STALL_INJ_EN enables per-tile response stall injection.
module l2_tile_rsp_model #(
  parameter int TILES     = msb_pkg::TILES,
  parameter int DEPTH     = msb_pkg::DEPTH,
  parameter int LATENCY   = msb_pkg::LATENCY,
  parameter int occ_width = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [TILES-1:0]                     i_req_v,
  output logic [TILES-1:0]                     i_req_r,
  input  logic [TILES*msb_pkg::clid_width-1:0] i_req_clid,
  output logic [TILES-1:0]                     o_rsp_v,
  input  logic [TILES-1:0]                     o_rsp_r,
  output logic [TILES*msb_pkg::clid_width-1:0] o_rsp_clid,
  output logic [TILES*occ_width-1:0]           o_occ
);
  import msb_pkg::*;

  for (genvar g = 0; g < TILES; g++) begin : g_tile
    l2_tile_rsp_chan #(
      .DEPTH    (DEPTH),
      .LATENCY  (LATENCY),
`ifdef L2_STALL_INJ_EN
      .TILE_IDX (g),
`endif
      .OCC_W    (occ_width)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_reqV    (i_req_v[g]),
      .o_reqRdy  (i_req_r[g]),
      .i_reqClid (i_req_clid[g*clid_width +: clid_width]),
      .o_rspV    (o_rsp_v[g]),
      .i_rspRdy  (o_rsp_r[g]),
      .o_rspClid (o_rsp_clid[g*clid_width +: clid_width]),
      .o_occ     (o_occ[g*occ_width +: occ_width])
    );
  end

endmodule

// File: tb/tb_l2_tile_rsp_model.sv
// Directed and scoreboarded bench for l2_tile_rsp_model at default parameters (4 tiles, clid 4b, depth 8, latency 4).
// Exact-timing sequences are compiled only when L2_STALL_INJ_EN is undefined.
module tb_l2_tile_rsp_model;
  import msb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  reqV, reqR, rspV, rspR;
  logic [15:0] reqClid, rspClid, occ;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycNum      = 0;

  int sbClid [4][$];
  int sbEdge [4][$];

  typedef struct {
    logic [3:0]  reqV;
    logic [15:0] reqClid;
    logic [3:0]  rspR;
    logic [3:0]  expV;
    logic [15:0] expClid;
    logic [3:0]  expRdy;
    logic [15:0] expOcc;
  } vec_t;

  vec_t        vecs [12];
  logic [15:0] clidMask;
  logic        holdR, prevHeld;
  logic [3:0]  prevC, prevHold, rv, rr;
  logic [15:0] rc, prevClid;
  int          sent, got, lat;

  l2_tile_rsp_model dut (
    .clk        (clk),
    .reset      (reset),
    .i_req_v    (reqV),
    .i_req_r    (reqR),
    .i_req_clid (reqClid),
    .o_rsp_v    (rspV),
    .o_rsp_r    (rspR),
    .o_rsp_clid (rspClid),
    .o_occ      (occ)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycNum++;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] cl, input logic [3:0] r);
    reqV    = v;
    reqClid = cl;
    rspR    = r;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s[%0d]: actual %0h, required %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog[0]: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // One tile-0 request (clid 5), then all four tiles at once (clid = tile index).
    vecs[0]  = '{4'h1, 16'h0005, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h0001};
    vecs[1]  = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h0001};
    vecs[2]  = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h0001};
    vecs[3]  = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h0001};
    vecs[4]  = '{4'h0, 16'h0000, 4'hF, 4'h1, 16'h0005, 4'hF, 16'h0001};
    vecs[5]  = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h0000};
    vecs[6]  = '{4'hF, 16'h3210, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h1111};
    vecs[7]  = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h1111};
    vecs[8]  = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h1111};
    vecs[9]  = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h1111};
    vecs[10] = '{4'h0, 16'h0000, 4'hF, 4'hF, 16'h3210, 4'hF, 16'h1111};
    vecs[11] = '{4'h0, 16'h0000, 4'hF, 4'h0, 16'h0000, 4'hF, 16'h0000};

    reset = 1'b1;
    applyStimulus(4'h0, 16'h0000, 4'hF);
    #12;
    reset = 1'b0;
    checkOutput("rstRspV", 0, rspV, 4'h0);
    checkOutput("rstClid", 0, rspClid, 16'h0000);
    checkOutput("rstReqR", 0, reqR, 4'hF);
    checkOutput("rstOcc", 0, occ, 16'h0000);
    tick();

`ifndef L2_STALL_INJ_EN
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].reqV, vecs[i].reqClid, vecs[i].rspR);
      tick();
      checkOutput("vecRspV", i, rspV, vecs[i].expV);
      checkOutput("vecReqR", i, reqR, vecs[i].expRdy);
      checkOutput("vecOcc", i, occ, vecs[i].expOcc);
      if (vecs[i].expV != 4'h0) begin
        clidMask = '0;
        for (int t = 0; t < 4; t++) if (vecs[i].expV[t]) clidMask[t*4 +: 4] = 4'hF;
        checkOutput("vecClid", i, rspClid & clidMask, vecs[i].expClid & clidMask);
      end
    end

    // Fill tile 2 with clid 0..7 under backpressure, then drain at full rate.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0100, 16'(k << 8), 4'h0);
      tick();
      checkOutput("fillOcc", k, occ[11:8], k + 1);
      checkOutput("fillRdy", k, reqR[2], (k < 7));
    end
    applyStimulus(4'h0, 16'h0000, 4'h0);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(4'h0, 16'h0000, 4'b0100);
      checkOutput("drainV", j, rspV[2], 1);
      checkOutput("drainClid", j, rspClid[11:8], j);
      tick();
      if (j == 0) checkOutput("rdyBack", j, reqR[2], 1);
    end
    checkOutput("drainDoneV", 0, rspV[2], 0);
    checkOutput("drainDoneOcc", 0, occ[11:8], 0);

    // Tile 1 holds clid 8..15 while ready toggles 1,0,1,0...
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0010, 16'((8 + k) << 4), 4'h0);
      tick();
    end
    applyStimulus(4'h0, 16'h0000, 4'h0);
    got = 0;
    prevHeld = 1'b0;
    prevC = 4'h0;
    for (int c = 0; c < 64 && got < 8; c++) begin
      if (prevHeld) begin
        checkOutput("holdV", c, rspV[1], 1);
        checkOutput("holdClid", c, rspClid[7:4], prevC);
      end
      holdR = (c % 2 == 0);
      applyStimulus(4'h0, 16'h0000, {2'b00, holdR, 1'b0});
      if (rspV[1] && holdR) begin
        checkOutput("holdOrder", got, rspClid[7:4], 8 + got);
        got++;
      end
      prevHeld = rspV[1] && !holdR;
      prevC = rspClid[7:4];
      tick();
    end
    checkOutput("holdCount", 0, got, 8);
    checkOutput("holdOcc", 0, occ[7:4], 0);

    // Reset mid-flight with three entries on tile 3, then a fresh request.
    applyStimulus(4'b1000, 16'h1000, 4'h0);
    tick();
    applyStimulus(4'b1000, 16'h2000, 4'h0);
    tick();
    applyStimulus(4'b1000, 16'h3000, 4'h0);
    tick();
    applyStimulus(4'h0, 16'h0000, 4'h0);
    tick();
    tick();
    tick();
    checkOutput("preRstV", 0, rspV[3], 1);
    checkOutput("preRstOcc", 0, occ[15:12], 3);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midRstV", 0, rspV, 4'h0);
    checkOutput("midRstOcc", 0, occ, 16'h0000);
    checkOutput("midRstReqR", 0, reqR, 4'hF);
    #2;
    reset = 1'b0;
    tick();
    applyStimulus(4'h1, 16'h0009, 4'hF);
    tick();
    applyStimulus(4'h0, 16'h0000, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("postRstV", k, rspV[0], (k == 4));
    end
    checkOutput("postRstClid", 0, rspClid[3:0], 9);
    tick();
    checkOutput("postRstDone", 0, rspV[0], 0);
`endif

    // Random traffic on all tiles against a per-tile FIFO scoreboard.
    sent = 0;
    got = 0;
    prevHold = 4'h0;
    prevClid = 16'h0000;
    for (int c = 0; c < 20000 && (sent < 1000 || got < sent); c++) begin
      for (int t = 0; t < 4; t++) begin
        if (prevHold[t]) begin
          checkOutput("rndHoldV", t, rspV[t], 1);
          checkOutput("rndHoldClid", t, rspClid[t*4 +: 4], prevClid[t*4 +: 4]);
        end
      end
      rv = (sent < 1000) ? 4'($urandom) : 4'h0;
      rc = 16'($urandom);
      for (int t = 0; t < 4; t++) rr[t] = ($urandom_range(0, 3) != 0);
      applyStimulus(rv, rc, rr);
      for (int t = 0; t < 4; t++) begin
        if (rspV[t] && rr[t]) begin
          if (sbClid[t].size() == 0) begin
            checkOutput("rndSpurious", t, rspV[t], 0);
          end else begin
            checkOutput("rndOrder", got, rspClid[t*4 +: 4], sbClid[t].pop_front());
            lat = cycNum + 1 - sbEdge[t].pop_front();
            checkOutput("rndLatency", got, (lat > LATENCY), 1);
            got++;
          end
        end
        if (rv[t] && reqR[t]) begin
          sbClid[t].push_back(int'(rc[t*4 +: 4]));
          sbEdge[t].push_back(cycNum + 1);
          sent++;
        end
      end
      prevHold = rspV & ~rr;
      prevClid = rspClid;
      tick();
    end
    checkOutput("rndDrained", 0, got, sent);
    checkOutput("rndOccZero", 0, occ, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
